// File: rtl/turn_controller_pkg.sv
// Shared Connect-4 types and board defaults for the game sequencer and its helpers.
package connect4_pkg;

   localparam int COLS_DEF = 7;
   localparam int ROWS_DEF = 6;

   localparam logic [2:0] S_SELECT = 3'd0;
   localparam logic [2:0] S_PLACE  = 3'd1;
   localparam logic [2:0] S_CHECK  = 3'd2;
   localparam logic [2:0] S_WIN    = 3'd3;
   localparam logic [2:0] S_DRAW   = 3'd4;
   localparam logic [2:0] S_CLEAR  = 3'd5;

   typedef enum logic [2:0] {
      SELECT = S_SELECT,
      PLACE  = S_PLACE,
      CHECK  = S_CHECK,
      WIN    = S_WIN,
      DRAW   = S_DRAW,
      CLEAR  = S_CLEAR
   } state_t;

   typedef logic player_t;

endpackage

// File: rtl/turn_controller_if.sv
// Place handshake between the turn sequencer (master) and the board store (slave).
interface turn_controller_if #(
   parameter int COLS = 7,
   parameter int ROWS = 6
);
   logic                        place_valid;
   logic                        place_ready;
   logic [$clog2(COLS)-1:0]     place_col;
   logic [$clog2(ROWS+1)-1:0]   place_row;
   logic                        place_player;

   modport master (
      output place_valid, place_col, place_row, place_player,
      input  place_ready
   );

   modport slave (
      input  place_valid, place_col, place_row, place_player,
      output place_ready
   );
endinterface

// File: rtl/turn_controller_column_height_tracker.sv
// Per-column piece heights: read port at the cursor, increment on accepted place, bulk clear.
module column_height_tracker #(
   parameter int COLS = 7,
   parameter int ROWS = 6
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic [$clog2(COLS)-1:0]     rd_col,
   output logic [$clog2(ROWS+1)-1:0]   rd_height,
   output logic                        full,
   input  logic                        inc,
   input  logic [$clog2(COLS)-1:0]     inc_col
);
   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS+1);

   logic [ROW_W-1:0] heights_q [COLS];
   logic [ROW_W-1:0] heights_d [COLS];

   always_comb begin
      for (int i = 0; i < COLS; i++) begin
         heights_d[i] = heights_q[i];
         if (clear)
            heights_d[i] = '0;
         else if (inc && inc_col == COL_W'(i))
            heights_d[i] = heights_q[i] + ROW_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < COLS; i++) heights_q[i] <= '0;
      end else begin
         for (int i = 0; i < COLS; i++) heights_q[i] <= heights_d[i];
      end
   end

   // Mux over a decoded compare so a non-power-of-two COLS never indexes past the array.
   always_comb begin
      rd_height = '0;
      for (int i = 0; i < COLS; i++)
         if (rd_col == COL_W'(i)) rd_height = heights_q[i];
   end

   assign full = (rd_height == ROW_W'(ROWS));

endmodule

// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: cursor, drop/place/check handshake, scoring, round restart.
// Optional turn forfeit timer enabled by defining TURN_TIMEOUT_EN.
module turn_controller
   import connect4_pkg::*;
#(
   parameter int COLS           = COLS_DEF,
   parameter int ROWS           = ROWS_DEF,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    btn_left,
   input  logic                    btn_right,
   input  logic                    btn_drop,
   turn_controller_if.master       place,
   input  logic                    check_done,
   input  logic                    check_win,
   output logic                    score_en_p1,
   output logic                    score_en_p2,
   output logic                    clear_board,
   output logic [$clog2(COLS)-1:0] cursor_col,
   output logic                    cur_player,
   output logic                    drop_reject,
   output logic                    game_over
);
   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS+1);
   localparam int CNT_W = $clog2(ROWS*COLS+1);
   localparam logic [COL_W-1:0] MID_COL  = COL_W'(COLS/2);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS-1);
   localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(ROWS*COLS);

   state_t           state_q, state_d;
   logic [COL_W-1:0] cursor_q, cursor_d;
   player_t          player_q, player_d;
   player_t          starter_q, starter_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [COL_W-1:0] pcol_q, pcol_d;
   logic [ROW_W-1:0] prow_q, prow_d;
   player_t          pplr_q, pplr_d;
   logic             valid_q, valid_d;
   logic             reject_q, reject_d;
   logic             sc1_q, sc1_d;
   logic             sc2_q, sc2_d;
   logic             clear_q, clear_d;
   logic             over_q, over_d;

   logic             inc;
   logic             clr;
   logic [ROW_W-1:0] height;
   logic             full;

   column_height_tracker #(.COLS(COLS), .ROWS(ROWS)) u_heights (
      .clock     (clock),
      .reset     (reset),
      .clear     (clr),
      .rd_col    (cursor_q),
      .rd_height (height),
      .full      (full),
      .inc       (inc),
      .inc_col   (pcol_q)
   );

`ifdef TURN_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMR_W-1:0] timer_q, timer_d;
`endif

   always_comb begin
      state_d   = state_q;
      cursor_d  = cursor_q;
      player_d  = player_q;
      starter_d = starter_q;
      count_d   = count_q;
      pcol_d    = pcol_q;
      prow_d    = prow_q;
      pplr_d    = pplr_q;
      reject_d  = 1'b0;
      sc1_d     = 1'b0;
      sc2_d     = 1'b0;
      inc       = 1'b0;
      clr       = 1'b0;

      case (state_q)
         SELECT: begin
            // Drop takes priority; a same-cycle move is discarded so the drop uses the old cursor.
            if (btn_drop) begin
               if (full) begin
                  reject_d = 1'b1;
               end else begin
                  pcol_d  = cursor_q;
                  prow_d  = height;
                  pplr_d  = player_q;
                  state_d = PLACE;
               end
            end else if (btn_left && !btn_right) begin
               cursor_d = (cursor_q == '0) ? LAST_COL : cursor_q - COL_W'(1);
            end else if (btn_right && !btn_left) begin
               cursor_d = (cursor_q == LAST_COL) ? '0 : cursor_q + COL_W'(1);
            end
         end
         PLACE: begin
            if (place.place_ready) begin
               inc     = 1'b1;
               count_d = count_q + CNT_W'(1);
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (check_done) begin
               if (check_win) begin
                  state_d = WIN;
                  sc1_d   = (pplr_q == 1'b0);
                  sc2_d   = (pplr_q == 1'b1);
               end else if (count_q == ALL_CNT) begin
                  state_d = DRAW;
               end else begin
                  player_d = ~player_q;
                  state_d  = SELECT;
               end
            end
         end
         WIN, DRAW: begin
            if (btn_drop) state_d = CLEAR;
         end
         CLEAR: begin
            clr       = 1'b1;
            count_d   = '0;
            cursor_d  = MID_COL;
            starter_d = ~starter_q;
            player_d  = ~starter_q;
            state_d   = SELECT;
         end
         default: state_d = SELECT;
      endcase

`ifdef TURN_TIMEOUT_EN
      // Timer only runs while staying in SELECT; a rejected drop keeps it running.
      timer_d = '0;
      if (state_q == SELECT && state_d == SELECT) begin
         if (timer_q == TMR_W'(TIMEOUT_CYCLES-1)) begin
            player_d = ~player_q;
            timer_d  = '0;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end
`endif

      valid_d = (state_d == PLACE);
      clear_d = (state_d == CLEAR);
      over_d  = (state_d == WIN) || (state_d == DRAW);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= SELECT;
         cursor_q  <= MID_COL;
         player_q  <= 1'b0;
         starter_q <= 1'b0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         reject_q  <= 1'b0;
         sc1_q     <= 1'b0;
         sc2_q     <= 1'b0;
         clear_q   <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cursor_q  <= cursor_d;
         player_q  <= player_d;
         starter_q <= starter_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         reject_q  <= reject_d;
         sc1_q     <= sc1_d;
         sc2_q     <= sc2_d;
         clear_q   <= clear_d;
         over_q    <= over_d;
      end
   end

   // Move payload is qualified by place_valid, so it carries no reset.
   always_ff @(posedge clock) begin
      pcol_q <= pcol_d;
      prow_q <= prow_d;
      pplr_q <= pplr_d;
   end

`ifdef TURN_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) timer_q <= '0;
      else       timer_q <= timer_d;
   end
`endif

   assign place.place_valid  = valid_q;
   assign place.place_col    = pcol_q;
   assign place.place_row    = prow_q;
   assign place.place_player = pplr_q;
   assign score_en_p1        = sc1_q;
   assign score_en_p2        = sc2_q;
   assign clear_board        = clear_q;
   assign cursor_col         = cursor_q;
   assign cur_player         = player_q;
   assign drop_reject        = reject_q;
   assign game_over          = over_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: cursor, handshake, reject, win, draw, restart and reset.
module tb_turn_controller;
   localparam int COLS = 7;
   localparam int ROWS = 6;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0;
   logic       check_done = 1'b0, check_win = 1'b0;
   logic       score_en_p1, score_en_p2, clear_board, cur_player, drop_reject, game_over;
   logic [2:0] cursor_col;

   int n_assert = 0;
   int n_fail   = 0;
   int score_cnt = 0;

   turn_controller_if #(.COLS(COLS), .ROWS(ROWS)) pif ();

   turn_controller #(.COLS(COLS), .ROWS(ROWS), .TIMEOUT_CYCLES(10)) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_drop    (btn_drop),
      .place       (pif),
      .check_done  (check_done),
      .check_win   (check_win),
      .score_en_p1 (score_en_p1),
      .score_en_p2 (score_en_p2),
      .clear_board (clear_board),
      .cursor_col  (cursor_col),
      .cur_player  (cur_player),
      .drop_reject (drop_reject),
      .game_over   (game_over)
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (score_en_p1 || score_en_p2) score_cnt++;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input bit l, input bit r, input bit d);
      btn_left = l; btn_right = r; btn_drop = d;
      step();
      btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
   endtask

   task automatic play(input bit win, input int exp_row, input bit exp_plr, input int exp_col);
      press(0, 0, 1);
      chk("play_valid", pif.place_valid, 1);
      chk("play_col", pif.place_col, exp_col);
      chk("play_row", pif.place_row, exp_row);
      chk("play_player", pif.place_player, exp_plr);
      pif.place_ready = 1'b1;
      step();
      pif.place_ready = 1'b0;
      chk("play_valid_low", pif.place_valid, 0);
      check_done = 1'b1; check_win = win;
      step();
      check_done = 1'b0; check_win = 1'b0;
   endtask

   initial begin
      int cols [7] = '{3, 4, 5, 6, 0, 1, 2};
      pif.place_ready = 1'b0;

      step(); step();
      chk("rst_cursor", cursor_col, 3);
      chk("rst_player", cur_player, 0);
      chk("rst_valid", pif.place_valid, 0);
      chk("rst_over", game_over, 0);
      chk("rst_clear", clear_board, 0);
      chk("rst_reject", drop_reject, 0);
      reset = 1'b0;

      // cursor movement and wrap
      press(0, 1, 0); chk("right1", cursor_col, 4);
      press(0, 1, 0); chk("right2", cursor_col, 5);
      press(0, 1, 0); chk("right3", cursor_col, 6);
      press(0, 1, 0); chk("right_wrap", cursor_col, 0);
      press(1, 0, 0); chk("left_wrap", cursor_col, 6);
      press(1, 1, 0); chk("both_nomove", cursor_col, 6);
      press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
      chk("left_to_3", cursor_col, 3);

      // drop with place_ready held low for three cycles
      press(0, 1, 1);
      chk("drop_cursor_kept", cursor_col, 3);
      for (int c = 0; c < 4; c++) begin
         chk("hold_valid", pif.place_valid, 1);
         chk("hold_col", pif.place_col, 3);
         chk("hold_row", pif.place_row, 0);
         chk("hold_player", pif.place_player, 0);
         if (c == 1) btn_right = 1'b1;
         if (c == 3) pif.place_ready = 1'b1;
         step();
         btn_right = 1'b0;
      end
      pif.place_ready = 1'b0;
      chk("hs_valid_low", pif.place_valid, 0);
      chk("place_ignores_btn", cursor_col, 3);
      check_done = 1'b1;
      step();
      check_done = 1'b0;
      chk("turn_to_p2", cur_player, 1);
      chk("no_over", game_over, 0);

      play(0, 1, 1, 3);
      chk("turn_to_p1", cur_player, 0);

      // fill column 0 then reject
      press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
      chk("cursor_0", cursor_col, 0);
      for (int k = 0; k < 6; k++) play(0, k, k % 2, 0);
      press(0, 0, 1);
      chk("reject_pulse", drop_reject, 1);
      chk("reject_no_valid", pif.place_valid, 0);
      chk("reject_player", cur_player, 0);
      step();
      chk("reject_once", drop_reject, 0);
      chk("reject_no_valid2", pif.place_valid, 0);

      // P2 wins
      press(0, 1, 0);
      play(0, 0, 0, 1);
      press(0, 0, 1);
      chk("win_row", pif.place_row, 1);
      chk("win_player", pif.place_player, 1);
      pif.place_ready = 1'b1; step(); pif.place_ready = 1'b0;
      check_done = 1'b1; check_win = 1'b1; step(); check_done = 1'b0; check_win = 1'b0;
      chk("win_sc2", score_en_p2, 1);
      chk("win_sc1", score_en_p1, 0);
      chk("win_over", game_over, 1);
      step();
      chk("win_sc2_low", score_en_p2, 0);
      chk("win_over_hold", game_over, 1);
      press(1, 0, 0);
      chk("win_ignore_left", cursor_col, 1);
      press(0, 0, 1);
      chk("clear_pulse", clear_board, 1);
      step();
      chk("clear_once", clear_board, 0);
      chk("new_starter", cur_player, 1);
      chk("clear_cursor", cursor_col, 3);
      chk("clear_over", game_over, 0);
      chk("score_count_win", score_cnt, 1);

      // 42 moves, no win
      for (int k = 0; k < 42; k++) begin
         play(0, k % 6, (1 + k) % 2, cols[k / 6]);
         if (k % 6 == 5 && k < 41) press(0, 1, 0);
      end
      chk("draw_over", game_over, 1);
      chk("draw_no_score", score_cnt, 1);
      chk("draw_player", cur_player, 0);
      press(0, 0, 1);
      chk("draw_clear", clear_board, 1);
      step();
      chk("draw_starter", cur_player, 0);
      chk("draw_cursor", cursor_col, 3);

      // reset during the handshake
      play(0, 0, 0, 3);
      press(0, 0, 1);
      chk("pre_rst_valid", pif.place_valid, 1);
      chk("pre_rst_row", pif.place_row, 1);
      reset = 1'b1;
      step();
      chk("mid_rst_valid", pif.place_valid, 0);
      chk("mid_rst_player", cur_player, 0);
      chk("mid_rst_cursor", cursor_col, 3);
      reset = 1'b0;
      press(0, 0, 1);
      chk("post_rst_row", pif.place_row, 0);
      chk("post_rst_player", pif.place_player, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;

`ifdef TURN_TIMEOUT_EN
      repeat (9) step();
      chk("tmo_before", cur_player, 0);
      step();
      chk("tmo_first", cur_player, 1);
      repeat (9) step();
      chk("tmo_hold", cur_player, 1);
      step();
      chk("tmo_second", cur_player, 0);
`else
      repeat (12) step();
      chk("no_timeout", cur_player, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/turn_controller.md
# turn_controller

Game sequencer for the Connect-4 board. It turns debounced player buttons into column moves and alternates turns between player 1 and player 2. It drives the place/check handshake toward the board store and win checker, and issues one-cycle increment enables to the two `score_system` instances. It sits between the input debouncers and the board/score datapath.

## Interface
- `COLS`, default 7: number of board columns; cursor range 0..COLS-1.
- `ROWS`, default 6: number of board rows; column height range 0..ROWS.
- `TIMEOUT_CYCLES`, default 50_000_000: turn timeout length; used only with `TURN_TIMEOUT_EN`.
- `clock` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `btn_left`, `btn_right`, `btn_drop` in 1 each: single-cycle debounced button pulses.
- `place_valid` out 1: move request to the board store.
- `place_ready` in 1: board store accepts the move.
- `place_col` out $clog2(COLS): target column.
- `place_row` out $clog2(ROWS+1): target row, 0 = bottom.
- `place_player` out 1: 0 = P1, 1 = P2.
- `check_done` in 1: win checker result valid; sampled only in CHECK.
- `check_win` in 1: the last move completed four in a row; qualified by `check_done`.
- `score_en_p1`, `score_en_p2` out 1 each: one-cycle pulses to the score counters.
- `clear_board` out 1: one-cycle pulse that wipes the board store.
- `cursor_col` out $clog2(COLS): current cursor position.
- `cur_player` out 1: player whose turn it is.
- `drop_reject` out 1: one-cycle pulse when a drop targets a full column.
- `game_over` out 1: high in WIN and DRAW.

## Operation
- States: SELECT, PLACE, CHECK, WIN, DRAW, CLEAR.
- Reset values:
  - State SELECT.
  - `cursor_col` = COLS/2 (3).
  - `cur_player` = 0 and round starter = 0.
  - All column heights = 0 and piece count = 0.
  - All pulse outputs, `place_valid` and `game_over` = 0.
- SELECT, cursor movement:
  - `btn_left` decrements `cursor_col`; it wraps from 0 to COLS-1.
  - `btn_right` increments `cursor_col`; it wraps from COLS-1 to 0.
  - `btn_left` and `btn_right` asserted together: no move.
- SELECT, drop:
  - `btn_drop` on a non-full column (height < ROWS) latches `place_col` = cursor, `place_row` = height, `place_player` = `cur_player`, and moves to PLACE.
  - `btn_drop` on a full column pulses `drop_reject` and stays in SELECT.
  - `btn_drop` wins over a same-cycle left/right; the move is ignored and the drop uses the pre-move cursor.
- PLACE:
  - `place_valid` is held high and `place_col`/`place_row`/`place_player` stay stable until `place_ready`.
  - On `place_valid && place_ready`: increment that column's height and the piece count, then move to CHECK.
- CHECK, on `check_done`:
  - If `check_win`: go to WIN and pulse `score_en_p1` or `score_en_p2` for `place_player`.
  - Else if piece count == ROWS*COLS: go to DRAW with no score pulse.
  - Else: toggle `cur_player` and return to SELECT.
- WIN and DRAW:
  - `game_over` is high.
  - `btn_drop` moves to CLEAR; all other buttons are ignored.
- CLEAR, lasting one cycle:
  - `clear_board` = 1.
  - Heights and piece count are zeroed and the cursor returns to COLS/2.
  - The round starter toggles and `cur_player` is set to the new starter.
  - Next state is SELECT.
- Buttons are ignored in PLACE, CHECK and CLEAR, with no queueing.
- Reset asserted in any state, including mid-handshake, returns to reset values on the next edge. `place_valid` drops without waiting for `place_ready`.

## Timing
- Drop pulse at cycle t in SELECT -> `place_valid` high from t+1.
- Handshake completes at edge t+k -> state CHECK and the height update are visible at t+k+1.
- `check_done && check_win` at cycle c -> `score_en_px` = 1 and `game_over` = 1 at c+1; `score_en_px` = 0 at c+2.
- `clear_board` is high for exactly the one cycle after the accepting `btn_drop`.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - A turn timer counts cycles while in SELECT and restarts on every entry to SELECT.
  - On reaching TIMEOUT_CYCLES-1 with no accepted drop, `cur_player` toggles (turn forfeited) and the timer restarts.
  - A rejected drop does not restart the timer.
- `TURN_TIMEOUT_EN` undefined: no timer logic; SELECT waits indefinitely.

## Structure
- Package `connect4_pkg`:
  - `state_t` enum.
  - `player_t` (1 bit).
  - `COLS_DEF` = 7 and `ROWS_DEF` = 6.
- Sub-module `column_height_tracker`:
  - Holds the per-column heights.
  - Provides a read port at the cursor, an increment-on-place input and a clear input.
  - Outputs `full` for the addressed column.
- The FSM, cursor, piece counter and optional timer live in `turn_controller`.

## Test plan
- After reset, 4× `btn_right` -> `cursor_col` steps 4,5,6,0. Then 1× `btn_left` -> 6.
- Drop at column 3, hold `place_ready` low 3 cycles -> `place_valid` is high for 4 cycles with col = 3, row = 0, player = 0 stable. Next drop in column 3 by P2 -> row = 1, player = 1.
- Fill column 0 with 6 pieces, then drop on it again -> `drop_reject` pulses once, no `place_valid`, `cur_player` unchanged.
- `check_done` = 1 with `check_win` = 1 on a P2 move -> `score_en_p2` is high exactly 1 cycle and `game_over` = 1. `btn_drop` -> one `clear_board` cycle, then SELECT with `cur_player` = 1, cursor = 3.
- Play 42 moves with no win -> DRAW and `game_over` = 1, with no score pulse at any point.
- Assert `reset` while `place_valid` = 1 -> the next cycle shows `place_valid` = 0, state SELECT and heights 0. With `TURN_TIMEOUT_EN` and TIMEOUT_CYCLES = 10, idle in SELECT -> `cur_player` toggles every 10 cycles.
